// File: rtl/digi_source_tx_if.sv
// Control and waveform signals of the interval-table pattern generator.
// The master drives table writes and pattern control; the slave returns the waveform and status.
interface digi_source_tx_if #(
    parameter int CW   = 16,
    parameter int NMAX = 8
);
    localparam int AW = (NMAX > 1) ? $clog2(NMAX) : 1;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic [AW:0]   n_int;
    logic          rpt;
    logic          start;
    logic          stop;
    logic          dout;
    logic          busy;
    logic          edge_stb;
    logic          done;
    logic          wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, n_int, rpt, start, stop,
        input  dout, busy, edge_stb, done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, n_int, rpt, start, stop,
        output dout, busy, edge_stb, done, wr_err
    );
endinterface

// File: rtl/digi_source_tx.sv
// Digital pattern source: dout toggles after each programmed interval in a small table,
// optionally looping; three-state control (IDLE/RUN/FIN) with write protection while running.
module digi_source_tx #(
    parameter int   CW   = 16,
    parameter int   NMAX = 8,
    parameter logic INIT = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    digi_source_tx_if.slave  bus
);
    localparam int AW = (NMAX > 1) ? $clog2(NMAX) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW:0]   n_q, n_d;
    logic          rep_q, rep_d;
    logic          dout_q, dout_d;
    logic          edge_q, edge_d;
    logic          werr_q, werr_d;
    logic [CW-1:0] tab_q [NMAX];

    logic          wr_ok;
    logic [CW-1:0] tab0_eff;
    logic [AW-1:0] idx_nx;
    logic          wrap;

    function automatic logic [CW-1:0] hold(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    assign wr_ok    = bus.wr_en && (state_q != RUN) && ({1'b0, bus.wr_addr} < (AW+1)'(NMAX));
    // A write landing in the start cycle must be visible to the first interval load.
    assign tab0_eff = (wr_ok && bus.wr_addr == '0) ? bus.wr_data : tab_q[0];
    assign idx_nx   = idx_q + AW'(1);
    assign wrap     = ({1'b0, idx_q} + (AW+1)'(1)) >= n_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        rep_d   = rep_q;
        dout_d  = dout_q;
        edge_d  = 1'b0;
        werr_d  = bus.wr_en && !wr_ok;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.n_int != '0) begin
                        n_d     = (bus.n_int > (AW+1)'(NMAX)) ? (AW+1)'(NMAX) : bus.n_int;
                        rep_d   = bus.rpt;
                        idx_d   = '0;
                        cnt_d   = hold(tab0_eff);
                        dout_d  = INIT;
                        state_d = RUN;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = FIN;
                end else if (cnt_q == CW'(1)) begin
                    if (!wrap) begin
                        idx_d  = idx_nx;
                        cnt_d  = hold(tab_q[idx_nx]);
                        dout_d = ~dout_q;
                        edge_d = 1'b1;
                    end else if (rep_q) begin
                        idx_d  = '0;
                        cnt_d  = hold(tab_q[0]);
                        dout_d = INIT;
                        edge_d = (dout_q != INIT);
                    end else begin
                        dout_d  = ~dout_q;
                        edge_d  = 1'b1;
                        state_d = FIN;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
                dout_d  = INIT;
                edge_d  = (dout_q != INIT);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            rep_q   <= 1'b0;
            dout_q  <= INIT;
            edge_q  <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            rep_q   <= rep_d;
            dout_q  <= dout_d;
            edge_q  <= edge_d;
            werr_q  <= werr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NMAX; i++) tab_q[i] <= '0;
        end else if (wr_ok) begin
            tab_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == FIN);
    assign bus.edge_stb = edge_q;
    assign bus.wr_err   = werr_q;
endmodule

// File: tb/tb_digi_source_tx.sv
// Scenario bench for digi_source_tx: expected {dout,busy,edge_stb,done} per cycle are queued
// when a pattern is launched and compared as the DUT produces them.
module tb_digi_source_tx;
    localparam int CW   = 8;
    localparam int NMAX = 6;
    localparam int AW   = 3;

    typedef struct packed {
        logic d;
        logic b;
        logic e;
        logic dn;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t ex, obs;

    digi_source_tx_if #(.CW(CW), .NMAX(NMAX)) bus ();

    digi_source_tx #(.CW(CW), .NMAX(NMAX), .INIT(1'b0)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int v);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = CW'(v);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic launch(input int n, input logic r);
        bus.n_int = 4'(n);
        bus.rpt   = r;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic push(input logic d, input logic b, input logic e, input logic dn);
        sbq.push_back('{d: d, b: b, e: e, dn: dn});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.n_int = 4'd2;
        tick(); tick();
        bus.start = 1'b0; bus.wr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            obs = {bus.dout, bus.busy, bus.edge_stb, bus.done};
            checks++;
            if (obs !== 4'b0000 || bus.wr_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: got %b werr=%b, expected 0000 werr=0", i, obs, bus.wr_err);
            end
            if (i == 0) begin reset = 1'b0; tick(); end
        end
    endtask

    task automatic test_pattern_3_2();
        push(0,1,0,0); push(0,1,0,0); push(0,1,0,0);
        push(1,1,1,0); push(1,1,0,0);
        push(0,0,1,1); push(0,0,0,0); push(0,0,0,0);
        launch(2, 1'b0);
        for (int i = 0; sbq.size() > 0; i++) begin
            ex  = sbq.pop_front();
            obs = {bus.dout, bus.busy, bus.edge_stb, bus.done};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL pattern_3_2 cyc%0d: got %b expected %b", i, obs, ex);
            end
            tick();
        end
    endtask

    task automatic test_repeat();
        wr(0, 2); wr(1, 2); wr(2, 1);
        for (int p = 0; p < 3; p++) begin
            push(0,1,0,0); push(0,1,0,0); push(1,1,1,0); push(1,1,0,0); push(0,1,1,0);
        end
        push(0,1,0,0); push(0,1,0,0);
        push(0,0,0,1); push(0,0,0,0);
        launch(3, 1'b1);
        for (int i = 0; sbq.size() > 0; i++) begin
            ex  = sbq.pop_front();
            obs = {bus.dout, bus.busy, bus.edge_stb, bus.done};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL repeat_stop cyc%0d: got %b expected %b", i, obs, ex);
            end
            // Stop lands on a cycle where the counter would otherwise toggle dout.
            bus.stop = (i == 16);
            tick();
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_zero_entry();
        wr(0, 0);
        push(0,1,0,0); push(1,0,1,1); push(0,0,1,0); push(0,0,0,0);
        launch(1, 1'b0);
        for (int i = 0; sbq.size() > 0; i++) begin
            ex  = sbq.pop_front();
            obs = {bus.dout, bus.busy, bus.edge_stb, bus.done};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL zero_entry cyc%0d: got %b expected %b", i, obs, ex);
            end
            tick();
        end
    endtask

    task automatic test_nint_zero();
        push(0,0,0,1); push(0,0,0,0); push(0,0,0,0);
        launch(0, 1'b0);
        for (int i = 0; sbq.size() > 0; i++) begin
            ex  = sbq.pop_front();
            obs = {bus.dout, bus.busy, bus.edge_stb, bus.done};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL nint_zero cyc%0d: got %b expected %b", i, obs, ex);
            end
            tick();
        end
    endtask

    task automatic test_wr_err();
        wr(0, 3);
        checks++;
        if (bus.wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_legal: got %b expected 0", bus.wr_err);
        end
        wr(1, 2);
        launch(2, 1'b0);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 8'd7;
        tick();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_busy: got %b expected 1", bus.wr_err);
        end
        tick();
        checks++;
        if (bus.wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_busy_pulse: got %b expected 0", bus.wr_err);
        end
        repeat (6) tick();
        wr(NMAX, 9);
        checks++;
        if (bus.wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_range: got %b expected 1", bus.wr_err);
        end
        tick();
        test_pattern_3_2();
    endtask

    task automatic test_write_start();
        wr(0, 1);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'd4;
        push(0,1,0,0); push(0,1,0,0); push(0,1,0,0); push(0,1,0,0);
        push(1,0,1,1); push(0,0,1,0); push(0,0,0,0);
        launch(1, 1'b0);
        bus.wr_en = 1'b0;
        for (int i = 0; sbq.size() > 0; i++) begin
            ex  = sbq.pop_front();
            obs = {bus.dout, bus.busy, bus.edge_stb, bus.done};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL write_start cyc%0d: got %b expected %b", i, obs, ex);
            end
            bus.start = (i == 1 || i == 4);
            tick();
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset_midrun();
        wr(0, 3); wr(1, 2);
        launch(2, 1'b0);
        repeat (3) tick();
        checks++;
        if (bus.dout !== 1'b1) begin
            errors++;
            $display("FAIL midrun_high: got %b expected 1", bus.dout);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            obs = {bus.dout, bus.busy, bus.edge_stb, bus.done};
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL midrun_reset cyc%0d: got %b expected 0000", i, obs);
            end
            tick();
        end
        push(0,1,0,0); push(1,1,1,0); push(0,0,1,1); push(0,0,0,0);
        launch(2, 1'b0);
        for (int i = 0; sbq.size() > 0; i++) begin
            ex  = sbq.pop_front();
            obs = {bus.dout, bus.busy, bus.edge_stb, bus.done};
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL table_zeroed cyc%0d: got %b expected %b", i, obs, ex);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.n_int = '0; bus.rpt = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        test_reset();
        wr(0, 3); wr(1, 2);
        test_pattern_3_2();
        test_repeat();
        test_zero_entry();
        test_nint_zero();
        test_wr_err();
        test_write_start();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
